pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a CTRL_W-bit control bundle and a DATA_W-bit payload bundle between two stages.
- Uses a valid/ready handshake with a one-entry skid buffer, a freeze input (cache-miss stall) and a flush input (branch/hazard bubble).
- Replaces the dual-edge temp/output scheme with a single rising-edge register pair.

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one-entry skid, freeze and flush; entry visible one edge after acceptance, 1 entry/cycle.
// Backpressure: in_ready_o drops while the skid holds an entry or on stall/flush. Optional counters: PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int                 CTRL_W      = 8,
  parameter int                 DATA_W      = 143,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] data_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`else
  output logic [DATA_W-1:0] data_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_e;

  logic              m_v, s_v;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              in_xfer, out_xfer;

  assign in_ready_o  = ~s_v & ~stall_i & ~flush_i;
  assign out_valid_o = m_v & ~stall_i;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  assign ctrl_o = m_v ? m_ctrl : BUBBLE_CTRL;
  assign data_o = m_data;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      m_v    <= 1'b0;
      s_v    <= 1'b0;
      m_ctrl <= BUBBLE_CTRL;
      s_ctrl <= BUBBLE_CTRL;
      m_data <= '0;
      s_data <= '0;
    end else if (flush_i) begin
      // Payload registers are left alone; only validity and control are cleared.
      m_v    <= 1'b0;
      s_v    <= 1'b0;
      m_ctrl <= BUBBLE_CTRL;
      s_ctrl <= BUBBLE_CTRL;
    end else if (!stall_i) begin
      case (state_e'({m_v, s_v}))
        EMPTY: begin
          if (in_xfer) begin
            m_v    <= 1'b1;
            m_ctrl <= ctrl_i;
            m_data <= data_i;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            m_ctrl <= ctrl_i;
            m_data <= data_i;
          end else if (out_xfer) begin
            m_v <= 1'b0;
          end else if (in_xfer) begin
            s_v    <= 1'b1;
            s_ctrl <= ctrl_i;
            s_data <= data_i;
          end
        end
        SKID: begin
          if (out_xfer) begin
            s_v    <= 1'b0;
            m_ctrl <= s_ctrl;
            m_data <= s_data;
          end
        end
        default: begin
          m_v <= 1'b0;
          s_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_i && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid_o && !stall_i && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid, stall, flush, reset and optional counters.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 143;

  logic              clk_i = 1'b0;
  logic              rst_i, stall_i, flush_i;
  logic              in_valid_i, in_ready_o;
  logic [CTRL_W-1:0] ctrl_i, ctrl_o;
  logic [DATA_W-1:0] data_i, data_o;
  logic              out_valid_o, out_ready_i;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt_o, bubble_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(8'h00)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
`ifdef PIPE_STAGE_PERF_EN
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`else
    .data_o      (data_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [CTRL_W-1:0] obs, input logic [CTRL_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input int d, input logic rdy);
    in_valid_i  = v;
    ctrl_i      = c;
    data_i      = DATA_W'(d);
    out_ready_i = rdy;
    #1;
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 8'h00, 0, 1'b0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    chk_b("rst_in_ready", in_ready_o, 1'b1);
    chk_b("rst_out_valid", out_valid_o, 1'b0);
    chk_c("rst_ctrl", ctrl_o, 8'h00);
    chk_d("rst_data", data_o, '0);

    // First entry, one-edge latency
    drive(1'b1, 8'hA5, 1, 1'b1);
    tick();
    chk_b("first_valid", out_valid_o, 1'b1);
    chk_c("first_ctrl", ctrl_o, 8'hA5);
    chk_d("first_data", data_o, DATA_W'(1));

    // Back-to-back stream 1..10 (entry 1 already in main)
    for (int i = 2; i <= 10; i++) begin
      drive(1'b1, CTRL_W'(i), i, 1'b1);
      chk_b("stream_ready", in_ready_o, 1'b1);
      tick();
      chk_b("stream_valid", out_valid_o, 1'b1);
      chk_d("stream_data", data_o, DATA_W'(i));
      chk_c("stream_ctrl", ctrl_o, CTRL_W'(i));
    end
    drive(1'b0, 8'h00, 0, 1'b1);
    tick();
    chk_b("drain_valid", out_valid_o, 1'b0);
    chk_c("drain_ctrl_bubble", ctrl_o, 8'h00);
    chk_d("drain_data_kept", data_o, DATA_W'(10));

    // Fill main, then skid with downstream blocked
    drive(1'b1, 8'h11, 1, 1'b1);
    tick();
    drive(1'b1, 8'h12, 2, 1'b0);
    chk_b("skid_ready_before", in_ready_o, 1'b1);
    tick();
    drive(1'b1, 8'h13, 3, 1'b0);
    chk_b("skid_ready_low", in_ready_o, 1'b0);
    chk_d("skid_main_data", data_o, DATA_W'(1));
    tick();
    chk_d("skid_hold_data", data_o, DATA_W'(1));
    chk_b("skid_hold_ready", in_ready_o, 1'b0);

    // Stall for 3 cycles in SKID; downstream ready must not drain anything
    stall_i = 1'b1;
    drive(1'b1, 8'h13, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk_b("stall_out_valid", out_valid_o, 1'b0);
      chk_b("stall_in_ready", in_ready_o, 1'b0);
      tick();
      chk_c("stall_ctrl", ctrl_o, 8'h11);
      chk_d("stall_data", data_o, DATA_W'(1));
    end
    stall_i = 1'b0;
    #1;
    chk_b("resume_valid", out_valid_o, 1'b1);
    chk_b("resume_ready_low", in_ready_o, 1'b0);
    tick();
    chk_d("resume_data2", data_o, DATA_W'(2));
    chk_c("resume_ctrl2", ctrl_o, 8'h12);
    chk_b("resume_ready_high", in_ready_o, 1'b1);
    tick();
    chk_d("resume_data3", data_o, DATA_W'(3));
    drive(1'b0, 8'h00, 0, 1'b1);
    tick();
    chk_b("resume_empty", out_valid_o, 1'b0);

    // Flush in SKID with an input presented
    drive(1'b1, 8'h14, 4, 1'b1);
    tick();
    drive(1'b1, 8'h15, 5, 1'b0);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 8'h16, 6, 1'b0);
    chk_b("flush_in_ready", in_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 0, 1'b1);
    chk_b("flush_valid", out_valid_o, 1'b0);
    chk_c("flush_ctrl", ctrl_o, 8'h00);
    chk_b("flush_ready", in_ready_o, 1'b1);
    chk_d("flush_data_kept", data_o, DATA_W'(4));
    tick();
    chk_b("flush_nothing_after", out_valid_o, 1'b0);
    chk_d("flush_no_data6", data_o, DATA_W'(4));

    // Stall and flush together: flush wins
    drive(1'b1, 8'h17, 7, 1'b0);
    tick();
    chk_b("sf_loaded", out_valid_o, 1'b1);
    drive(1'b0, 8'h00, 0, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    #1;
    chk_b("sf_valid", out_valid_o, 1'b0);
    chk_c("sf_ctrl", ctrl_o, 8'h00);

    // Reset mid-stream discards both entries
    drive(1'b1, 8'h18, 8, 1'b1);
    tick();
    chk_d("pre_rst_data", data_o, DATA_W'(8));
    drive(1'b1, 8'h19, 9, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    drive(1'b0, 8'h00, 0, 1'b1);
    chk_b("mid_rst_valid", out_valid_o, 1'b0);
    chk_d("mid_rst_data", data_o, '0);
    chk_c("mid_rst_ctrl", ctrl_o, 8'h00);
    chk_b("mid_rst_ready", in_ready_o, 1'b1);
    tick();
    chk_b("mid_rst_no_skid", out_valid_o, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    stall_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk_d("stall_cnt", DATA_W'(stall_cnt_o), DATA_W'(5));
    chk_d("bubble_cnt", DATA_W'(bubble_cnt_o), DATA_W'(3));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
